// File: rtl/ps2_direction_rx.sv
// PS/2 keyboard receiver and Tron direction decoder: synchronise, deglitch, deframe, decode.
// Define PS2_REVERSE_BLOCK_EN to discard headings that would reverse the snake onto itself.
module ps2_direction_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       keyboardCLK,
    input  logic       keyboardData,
    output logic [4:0] direction,
    output logic       restart,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN - 1);
    localparam logic [4:0] DIR_UP    = 5'b00010;
    localparam logic [4:0] DIR_LEFT  = 5'b00100;
    localparam logic [4:0] DIR_DOWN  = 5'b01000;
    localparam logic [4:0] DIR_RIGHT = 5'b10000;

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    logic [1:0]    clkSync_q, dataSync_q;
    logic [3:0]    clkCnt_q, dataCnt_q;
    logic          clkFilt_q, dataFilt_q, clkPrev_q;
    state_t        state_q;
    logic [3:0]    bitCnt_q;
    logic [9:0]    shift_q;
    logic [TW-1:0] timer_q;
    logic [7:0]    code_q;
    logic          codeValid_q, frameErr_q;
    logic          ext_q, brk_q, restart_q;
    logic [4:0]    dir_q;

    logic          fall_d;
    logic [9:0]    shift_d;
    logic          frameOk_d;
    logic [4:0]    heading_d;
    logic          space_d;
    logic          blocked_d;

    // A filtered level only follows the synchronised pin after FILTER_LEN agreeing samples.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            clkCnt_q   <= '0;
            dataCnt_q  <= '0;
            clkFilt_q  <= 1'b1;
            dataFilt_q <= 1'b1;
            clkPrev_q  <= 1'b1;
        end else begin
            clkSync_q  <= {clkSync_q[0], keyboardCLK};
            dataSync_q <= {dataSync_q[0], keyboardData};
            clkPrev_q  <= clkFilt_q;
            if (clkSync_q[1] != clkFilt_q) begin
                if (clkCnt_q == FILT_MAX) begin
                    clkFilt_q <= clkSync_q[1];
                    clkCnt_q  <= '0;
                end else begin
                    clkCnt_q <= clkCnt_q + 4'd1;
                end
            end else begin
                clkCnt_q <= '0;
            end
            if (dataSync_q[1] != dataFilt_q) begin
                if (dataCnt_q == FILT_MAX) begin
                    dataFilt_q <= dataSync_q[1];
                    dataCnt_q  <= '0;
                end else begin
                    dataCnt_q <= dataCnt_q + 4'd1;
                end
            end else begin
                dataCnt_q <= '0;
            end
        end
    end

    assign fall_d    = clkPrev_q & ~clkFilt_q;
    assign shift_d   = {dataFilt_q, shift_q[9:1]};
    assign frameOk_d = shift_d[9] & (^shift_d[8:0]);

    // Frame checks are resolved on the stop-bit edge so the pulses are high during CHECK.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            timer_q     <= '0;
            code_q      <= 8'h00;
            codeValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            codeValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q  <= '0;
                    bitCnt_q <= '0;
                    if (fall_d && !dataFilt_q) state_q <= RECV;
                end
                RECV: begin
                    if (fall_d) begin
                        shift_q  <= shift_d;
                        timer_q  <= '0;
                        bitCnt_q <= bitCnt_q + 4'd1;
                        if (bitCnt_q == 4'd9) begin
                            state_q <= CHECK;
                            if (frameOk_d) begin
                                code_q      <= shift_d[7:0];
                                codeValid_q <= 1'b1;
                            end else begin
                                frameErr_q <= 1'b1;
                            end
                        end
                    end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                        frameErr_q <= 1'b1;
                        state_q    <= IDLE;
                        bitCnt_q   <= '0;
                        timer_q    <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                CHECK: begin
                    state_q  <= IDLE;
                    bitCnt_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        heading_d = '0;
        space_d   = 1'b0;
        if (ext_q) begin
            case (code_q)
                8'h75:   heading_d = DIR_UP;
                8'h6B:   heading_d = DIR_LEFT;
                8'h72:   heading_d = DIR_DOWN;
                8'h74:   heading_d = DIR_RIGHT;
                default: heading_d = '0;
            endcase
        end else begin
            case (code_q)
                8'h1D:   heading_d = DIR_UP;
                8'h1C:   heading_d = DIR_LEFT;
                8'h1B:   heading_d = DIR_DOWN;
                8'h23:   heading_d = DIR_RIGHT;
                8'h29:   space_d   = 1'b1;
                default: heading_d = '0;
            endcase
        end
    end

`ifdef PS2_REVERSE_BLOCK_EN
    assign blocked_d = ((heading_d == DIR_UP)    && (dir_q == DIR_DOWN))  ||
                       ((heading_d == DIR_DOWN)  && (dir_q == DIR_UP))    ||
                       ((heading_d == DIR_LEFT)  && (dir_q == DIR_RIGHT)) ||
                       ((heading_d == DIR_RIGHT) && (dir_q == DIR_LEFT));
`else
    assign blocked_d = 1'b0;
`endif

    // E0/F0 are prefixes; the byte after them consumes and clears both flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            dir_q     <= DIR_RIGHT;
            restart_q <= 1'b0;
        end else begin
            restart_q <= 1'b0;
            if (codeValid_q) begin
                if (code_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (code_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    if (!brk_q) begin
                        if ((heading_d != '0) && !blocked_d) dir_q <= heading_d;
                        restart_q <= space_d;
                    end
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end
        end
    end

    assign direction  = dir_q;
    assign restart    = restart_q;
    assign code       = code_q;
    assign code_valid = codeValid_q;
    assign frame_err  = frameErr_q;

endmodule

// File: tb/tb_ps2_direction_rx.sv
// Self-checking bench for ps2_direction_rx: vector table, corner sequences, randomised frames vs model.
module tb_ps2_direction_rx;

    localparam int FL = 8;
    localparam int TO = 300;
    localparam int HP = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       keyboardCLK = 1'b1;
    logic       keyboardData = 1'b1;
    logic [4:0] direction;
    logic       restart;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;

    ps2_direction_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n), .keyboardCLK(keyboardCLK), .keyboardData(keyboardData),
        .direction(direction), .restart(restart), .code(code),
        .code_valid(code_valid), .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cvCount = 0, feCount = 0, rsCount = 0, widthErr = 0, orderErr = 0;
    logic prevCv = 1'b0, prevFe = 1'b0, prevRs = 1'b0;

    // Pulse monitor: counts one-cycle events and flags stretched or misordered pulses.
    always @(negedge clk) begin
        if (code_valid) cvCount++;
        if (frame_err) feCount++;
        if (restart) rsCount++;
        if ((code_valid && prevCv) || (frame_err && prevFe) || (restart && prevRs)) widthErr++;
        if (restart && !prevCv) orderErr++;
        prevCv = code_valid;
        prevFe = frame_err;
        prevRs = restart;
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

    // Behavioural reference: direction state from the decoded byte stream.
    logic [4:0] mDir;
    logic       mExt, mBrk;
    int         mRs;
    logic [7:0] mCode;

    function automatic logic opposite(input logic [4:0] a, input logic [4:0] b);
        return (a | b) == 5'b01010 || (a | b) == 5'b10100;
    endfunction

    task automatic modelReset();
        mDir = 5'b10000; mExt = 0; mBrk = 0; mRs = 0; mCode = 8'h00;
    endtask

    task automatic modelByte(input logic [7:0] b);
        logic [4:0] h;
        mCode = b;
        if (b == 8'hE0) mExt = 1;
        else if (b == 8'hF0) mBrk = 1;
        else begin
            h = 5'b0;
            if (!mBrk) begin
                if (mExt) h = (b == 8'h75) ? 5'b00010 : (b == 8'h6B) ? 5'b00100 :
                              (b == 8'h72) ? 5'b01000 : (b == 8'h74) ? 5'b10000 : 5'b0;
                else begin
                    h = (b == 8'h1D) ? 5'b00010 : (b == 8'h1C) ? 5'b00100 :
                        (b == 8'h1B) ? 5'b01000 : (b == 8'h23) ? 5'b10000 : 5'b0;
                    if (b == 8'h29) mRs++;
                end
`ifdef PS2_REVERSE_BLOCK_EN
                if (h != 0 && opposite(h, mDir)) h = 5'b0;
`endif
                if (h != 0) mDir = h;
            end
            mExt = 0; mBrk = 0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sendBits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            keyboardData = bits[i];
            repeat (HP) @(posedge clk);
            keyboardCLK = 1'b0;
            repeat (HP) @(posedge clk);
            keyboardCLK = 1'b1;
        end
        keyboardData = 1'b1;
    endtask

    function automatic logic [10:0] frameOf(input logic [7:0] b, input bit flip);
        return {1'b1, (~^b) ^ flip, b, 1'b0};
    endfunction

    task automatic applyStimulus(input logic [7:0] b, input bit flip);
        sendBits(frameOf(b, flip), 11);
        repeat (2 * HP) @(posedge clk);
    endtask

    task automatic doReset();
        @(posedge clk);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        reset_n = 1'b1;
        modelReset();
    endtask

    typedef struct {
        logic [7:0] data;
        bit         flip;
        logic [7:0] expCode;
        logic [4:0] expDir;
        int         expCv, expFe, expRs;
    } vec_t;

    vec_t vecs[10];
    int   cv0, fe0, rs0, rsBase;
    logic [7:0] pool[12];
    logic [4:0] leftDir;

    initial begin
`ifdef PS2_REVERSE_BLOCK_EN
        leftDir = 5'b10000;
`else
        leftDir = 5'b00100;
`endif
        vecs[0] = '{8'h1D, 0, 8'h1D, 5'b00010, 1, 0, 0};
        vecs[1] = '{8'hE0, 0, 8'hE0, 5'b00010, 1, 0, 0};
        vecs[2] = '{8'h74, 0, 8'h74, 5'b10000, 1, 0, 0};
        vecs[3] = '{8'hE0, 0, 8'hE0, 5'b10000, 1, 0, 0};
        vecs[4] = '{8'hF0, 0, 8'hF0, 5'b10000, 1, 0, 0};
        vecs[5] = '{8'h74, 0, 8'h74, 5'b10000, 1, 0, 0};
        vecs[6] = '{8'h23, 1, 8'h74, 5'b10000, 0, 1, 0};
        vecs[7] = '{8'h1C, 0, 8'h1C, leftDir,  1, 0, 0};
        vecs[8] = '{8'h1D, 0, 8'h1D, 5'b00010, 1, 0, 0};
        vecs[9] = '{8'h29, 0, 8'h29, 5'b00010, 1, 0, 1};
        pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h75, 8'h6B, 8'h72, 8'h74, 8'h5A};

        doReset();
        @(negedge clk);
        checkOutput("reset direction", 32'(direction), 32'h10);
        checkOutput("reset code", 32'(code), 32'h00);
        checkOutput("reset pulses", {29'b0, code_valid, frame_err, restart}, 32'h0);

        for (int i = 0; i < 10; i++) begin
            cv0 = cvCount; fe0 = feCount; rs0 = rsCount;
            applyStimulus(vecs[i].data, vecs[i].flip);
            checkOutput($sformatf("vec%0d code", i), 32'(code), 32'(vecs[i].expCode));
            checkOutput($sformatf("vec%0d direction", i), 32'(direction), 32'(vecs[i].expDir));
            checkOutput($sformatf("vec%0d code_valid", i), cvCount - cv0, vecs[i].expCv);
            checkOutput($sformatf("vec%0d frame_err", i), feCount - fe0, vecs[i].expFe);
            checkOutput($sformatf("vec%0d restart", i), rsCount - rs0, vecs[i].expRs);
        end

        // Timeout after a partial frame, then a clean frame must still decode.
        doReset();
        rsBase = rsCount;
        cv0 = cvCount; fe0 = feCount;
        sendBits(frameOf(8'h1C, 0), 5);
        repeat (TO + 50) @(posedge clk);
        checkOutput("timeout frame_err", feCount - fe0, 1);
        checkOutput("timeout code_valid", cvCount - cv0, 0);
        applyStimulus(8'h1C, 0);
        modelByte(8'h1C);
        checkOutput("after timeout direction", 32'(direction), 32'(mDir));
        checkOutput("after timeout code", 32'(code), 32'(mCode));

        // Short clock glitches must be filtered out entirely.
        cv0 = cvCount; fe0 = feCount;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            keyboardCLK = 1'b0;
            repeat (3) @(posedge clk);
            keyboardCLK = 1'b1;
            repeat (30) @(posedge clk);
        end
        checkOutput("glitch code_valid", cvCount - cv0, 0);
        checkOutput("glitch frame_err", feCount - fe0, 0);
        applyStimulus(8'h29, 0);
        modelByte(8'h29);
        checkOutput("space code_valid", cvCount - cv0, 1);
        checkOutput("space restart", rsCount - rsBase, mRs);

        // Reset mid-frame drops the partial frame silently.
        sendBits(frameOf(8'h1B, 0), 4);
        @(posedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset direction", 32'(direction), 32'h10);
        checkOutput("midreset code", 32'(code), 32'h00);
        reset_n = 1'b1;
        modelReset();
        rsBase = rsCount;
        fe0 = feCount;
        repeat (TO + 50) @(posedge clk);
        checkOutput("midreset no error", feCount - fe0, 0);
        applyStimulus(8'h1B, 0);
        modelByte(8'h1B);
        checkOutput("midreset recover direction", 32'(direction), 32'(mDir));

        // Randomised byte stream with occasional parity faults.
        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            bit flip;
            b = pool[$urandom_range(0, 11)];
            flip = ($urandom_range(0, 9) == 0);
            fe0 = feCount;
            applyStimulus(b, flip);
            if (!flip) modelByte(b);
            checkOutput($sformatf("rand%0d code", i), 32'(code), 32'(mCode));
            checkOutput($sformatf("rand%0d direction", i), 32'(direction), 32'(mDir));
            checkOutput($sformatf("rand%0d restart", i), rsCount - rsBase, mRs);
            checkOutput($sformatf("rand%0d frame_err", i), feCount - fe0, 32'(flip));
        end

        checkOutput("pulse width", widthErr, 0);
        checkOutput("restart order", orderErr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
